alu_result_fifo: RTL
====================

Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit ALU. Captures each 13-bit ALU result together with its 4-bit sel opcode tag into a small FIFO.
- Presents captured entries to the consumer (writeback/display logic) over a valid/ready handshake.
- Decouples the combinational ALU from a consumer that may stall.
- Reports occupancy and a sticky overflow flag when results arrive while the FIFO is full.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clr  input  1  synchronous flush; empties FIFO and clears ovf.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- in_result  input  13  ALU result.
- in_sel  input  4  ALU opcode that produced in_result.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer accepts head entry.
- out_result  output  13  head entry result; 0 when empty.
- out_sel  output  4  head entry opcode; 0 when empty.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (rst_n=0, async): write pointer=0, read pointer=0, count=0, ovf=0. Outputs: empty=1, full=0, out_valid=0, in_ready=1, out_result=0, out_sel=0. Storage array is not reset.
- Push: in_valid && in_ready at a clk edge writes {in_sel,in_result} at the write pointer and increments it mod DEPTH.
- Pop: out_valid && out_ready at a clk edge increments the read pointer mod DEPTH.
- First-word-fall-through: out_result/out_sel combinationally show the entry at the read pointer whenever !empty.
- Latency: a push into an empty FIFO is visible on out_* the cycle after the write edge.
- Simultaneous push and pop (possible only when 0<count<DEPTH): both happen; count unchanged; head advances.
- Full: in_ready=0, so a pop and an attempted push in the same cycle means only the pop occurs.
- Empty: out_valid=0; out_ready is ignored and no pointer moves.
- Overflow: in_valid=1 while full=1 drops the input and sets ovf=1. ovf stays set until clr or reset.
- clr=1: on that edge, pointers and count go to 0 and ovf goes to 0. clr has priority over push, pop and overflow set in the same cycle.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. Full and empty are distinguished by count, not by pointer compare.
- Reset mid-transfer: all in-flight entries are discarded immediately, with no clock needed.
- count, full, empty, ovf are registered or derived from registered state only; there is no combinational path from in_valid or out_ready to them.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined:
  - Each entry stores an extra bit: even parity (XOR reduction) of {in_sel,in_result}, computed at push.
  - Added output port out_parity (1 bit) shows the stored bit of the head entry; 0 when empty.
  - Storage width is 18 bits.
- Undefined: no out_parity port; storage width is 17 bits. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, drive in_valid=1 -> empty=1, count=0, in_ready=1, out_valid=0, out_result=0, ovf=0. Release rst_n -> still empty until first clk edge with in_valid.
- Single pass-through: push in_result=13'd8, in_sel=4'b0000 (6+2) into empty FIFO -> next cycle out_valid=1, out_result=8, out_sel=0, count=1. Pop with out_ready=1 -> empty=1, count=0.
- Fill and overflow (DEPTH=4): push results 8,4,12,3 with sel 0..3 -> full=1, in_ready=0, count=4. Fifth push of 13'd64 -> dropped, ovf=1. Pops then return 8,4,12,3 in order.
- Concurrent push/pop: count=2, push 13'd1 and pop together for 3 cycles -> count stays 2, entries pop in order with no loss. Pointers wrap past index 3 correctly.
- Flush priority: count=3, ovf=1, assert clr together with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1, ovf=0, nothing written.
- Async reset mid-stream: count=3, drop rst_n between clk edges -> empty=1 and count=0 immediately, before the next clk edge. With ALU_RESULT_PARITY_EN, push {sel=4'b0001, result=13'd7} -> out_parity=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through result FIFO behind the 8-bit ALU.
// Stores {sel, result} pairs and hands them to a consumer over valid/ready.
// Occupancy is tracked by an explicit counter, so full and empty never rely on
// pointer comparison. A sticky overflow flag records pushes that arrive while full.
// Optional build macro: ALU_RESULT_PARITY_EN adds a stored even-parity bit per
// entry and the out_parity output.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [12:0]   in_result,
  input  logic [3:0]    in_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [12:0]   out_result,
  output logic [3:0]    out_sel,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic          out_parity
`endif
);

  localparam int unsigned RW = 13;
  localparam int unsigned SW = 4;
`ifdef ALU_RESULT_PARITY_EN
  localparam int unsigned DW = RW + SW + 1;
`else
  localparam int unsigned DW = RW + SW;
`endif

  localparam logic [AW:0] CountMax = (AW+1)'(DEPTH);
  localparam logic [AW:0] CountOne = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic [DW-1:0] entry_in;
  logic [DW-1:0] head;

  // Status flags come straight from registered occupancy only.
  assign full      = (count_q == CountMax);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign in_ready  = ~full;
  assign out_valid = ~empty;

  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

`ifdef ALU_RESULT_PARITY_EN
  assign entry_in = {^{in_sel, in_result}, in_sel, in_result};
`else
  assign entry_in = {in_sel, in_result};
`endif

  assign head = mem[rd_ptr_q];

  // Storage write; the array itself is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr_q] <= entry_in;
    end
  end

  // Next-state for pointers, occupancy and overflow; flush beats everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer rollover is the modulo.
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
      if (in_valid && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Head entry falls through combinationally; outputs read as zero when empty.
  always_comb begin
    out_result = '0;
    out_sel    = '0;
`ifdef ALU_RESULT_PARITY_EN
    out_parity = 1'b0;
`endif
    if (!empty) begin
      out_result = head[RW-1:0];
      out_sel    = head[RW+SW-1:RW];
`ifdef ALU_RESULT_PARITY_EN
      out_parity = head[DW-1];
`endif
    end
  end

endmodule
